regfile_sequencer: RTL and testbench

//  Multi-cycle control FSM for the 4x10-bit dual-read/single-write register file.

---
 rtl/cpu_pkg.sv | 52 +++++
 rtl/ir_decode.sv | 45 ++++
 rtl/regfile_sequencer.sv | 130 +++++++++++++
 tb/tb_regfile_sequencer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the register-file sequencer.
// Contents:
//   OPC_*/RX_*/RY_*  bit positions of the instruction fields (10-bit layout)
//   opcode_e         4-bit instruction opcode (8..15 are illegal and execute as NOP)
//   alu_op_e         3-bit ALU function select (value 7 is never produced)
//   seq_state_e      sequencer FSM states
//   op_class_e       how an accepted instruction is sequenced
package cpu_pkg;

  localparam int OPC_MSB = 9;
  localparam int OPC_LSB = 6;
  localparam int RX_MSB  = 5;
  localparam int RX_LSB  = 4;
  localparam int RY_MSB  = 3;
  localparam int RY_LSB  = 2;

  typedef enum logic [3:0] {
    OP_LOAD = 4'd0,
    OP_MOV  = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_NOT  = 4'd7
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_PASSB = 3'd0,
    ALU_ADD   = 3'd1,
    ALU_SUB   = 3'd2,
    ALU_AND   = 3'd3,
    ALU_OR    = 3'd4,
    ALU_XOR   = 3'd5,
    ALU_NOTA  = 3'd6
  } alu_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD,
    S_RD,
    S_WB,
    S_NOP
  } seq_state_e;

  typedef enum logic [1:0] {
    CLS_LD,
    CLS_ALU,
    CLS_NOP
  } op_class_e;

endpackage

// File: rtl/ir_decode.sv
// Combinational instruction decoder.
// Ports:
//   ir      in   N   instruction word ([9:6] opcode, [5:4] Rx, [3:2] Ry, [1:0] ignored)
//   cls     out  2   sequencing class: LOAD, ALU (read + write-back) or NOP
//   alu_op  out  3   ALU function for ALU-class opcodes, PASSB otherwise
//   rx      out  AW  destination / operand A register
//   ry      out  AW  operand B register
module ir_decode
  import cpu_pkg::*;
#(
  parameter int N  = 10,
  parameter int AW = 2
) (
  input  logic [N-1:0]  ir,
  output op_class_e     cls,
  output alu_op_e       alu_op,
  output logic [AW-1:0] rx,
  output logic [AW-1:0] ry
);

  opcode_e opc;
  logic    unused_pad;

  assign opc        = opcode_e'(ir[OPC_MSB:OPC_LSB]);
  assign rx         = ir[RX_MSB:RX_LSB];
  assign ry         = ir[RY_MSB:RY_LSB];
  assign unused_pad = ^ir[RY_LSB-1:0];

  always_comb begin
    cls    = CLS_NOP;
    alu_op = ALU_PASSB;
    case (opc)
      OP_LOAD: cls = CLS_LD;
      OP_MOV:  begin cls = CLS_ALU; alu_op = ALU_PASSB; end
      OP_ADD:  begin cls = CLS_ALU; alu_op = ALU_ADD;   end
      OP_SUB:  begin cls = CLS_ALU; alu_op = ALU_SUB;   end
      OP_AND:  begin cls = CLS_ALU; alu_op = ALU_AND;   end
      OP_OR:   begin cls = CLS_ALU; alu_op = ALU_OR;    end
      OP_XOR:  begin cls = CLS_ALU; alu_op = ALU_XOR;   end
      OP_NOT:  begin cls = CLS_ALU; alu_op = ALU_NOTA;  end
      default: ;
    endcase
  end

endmodule

// File: rtl/regfile_sequencer.sv
// Multi-cycle control FSM for the 4x10-bit dual-read/single-write register file.
// One instruction is accepted per EXEC handshake; LOAD writes DIN in one cycle,
// ALU ops read/latch then write back the ALU result, illegal opcodes take one NOP cycle.
// Ports:
//   CLKb, RSTb            clock (rising edge), asynchronous active-low reset
//   INSTR, EXEC           instruction and its request strobe
//   BUSY, DONE            status: not idle / final cycle of an instruction
//   ENW, WRA              register file write port
//   ENR0, RDA0, ENR1, RDA1 register file read ports
//   EXT_EN, G_OUT         D-bus drivers (external data / ALU result), never both
//   ALU_LD, ALU_OP        ALU result latch strobe and function select
module regfile_sequencer
  import cpu_pkg::*;
#(
  parameter int N  = 10,
  parameter int AW = 2
) (
  input  logic          CLKb,
  input  logic          RSTb,
  input  logic [N-1:0]  INSTR,
  input  logic          EXEC,
  output logic          BUSY,
  output logic          DONE,
  output logic          ENW,
  output logic [AW-1:0] WRA,
  output logic          ENR0,
  output logic [AW-1:0] RDA0,
  output logic          ENR1,
  output logic [AW-1:0] RDA1,
  output logic          EXT_EN,
  output logic          ALU_LD,
  output logic [2:0]    ALU_OP,
  output logic          G_OUT
);

  seq_state_e    state, state_nx;
  logic [N-1:0]  ir;
  logic          accept;

  op_class_e     in_cls, ir_cls;
  alu_op_e       in_alu, ir_alu;
  logic [AW-1:0] in_rx, in_ry, ir_rx, ir_ry;
  logic          unused_dec;

  // The incoming word is classified to pick the next state; the held IR drives
  // the outputs, so nothing on INSTR/EXEC reaches an output combinationally.
  ir_decode #(.N(N), .AW(AW)) u_dec_in (
    .ir     (INSTR),
    .cls    (in_cls),
    .alu_op (in_alu),
    .rx     (in_rx),
    .ry     (in_ry)
  );

  ir_decode #(.N(N), .AW(AW)) u_dec_ir (
    .ir     (ir),
    .cls    (ir_cls),
    .alu_op (ir_alu),
    .rx     (ir_rx),
    .ry     (ir_ry)
  );

  assign unused_dec = ^{in_alu, in_rx, in_ry, ir_cls};

  // RD is the only non-final busy state; EXEC there is ignored, not queued.
  assign accept = EXEC && (state != S_RD);

  always_ff @(posedge CLKb or negedge RSTb) begin
    if (!RSTb) begin
      state <= S_IDLE;
      ir    <= '0;
    end else begin
      state <= state_nx;
      if (accept) ir <= INSTR;
    end
  end

  always_comb begin
    state_nx = S_IDLE;
    if (state == S_RD) begin
      state_nx = S_WB;
    end else if (accept) begin
      case (in_cls)
        CLS_LD:  state_nx = S_LD;
        CLS_ALU: state_nx = S_RD;
        default: state_nx = S_NOP;
      endcase
    end
  end

  always_comb begin
    BUSY   = (state != S_IDLE);
    DONE   = 1'b0;
    ENW    = 1'b0;
    WRA    = '0;
    ENR0   = 1'b0;
    RDA0   = '0;
    ENR1   = 1'b0;
    RDA1   = '0;
    EXT_EN = 1'b0;
    ALU_LD = 1'b0;
    ALU_OP = '0;
    G_OUT  = 1'b0;
    case (state)
      S_LD: begin
        EXT_EN = 1'b1;
        ENW    = 1'b1;
        WRA    = ir_rx;
        DONE   = 1'b1;
      end
      S_RD: begin
        ENR0   = 1'b1;
        RDA0   = ir_rx;
        ENR1   = 1'b1;
        RDA1   = ir_ry;
        ALU_LD = 1'b1;
        ALU_OP = ir_alu;
      end
      S_WB: begin
        G_OUT  = 1'b1;
        ENW    = 1'b1;
        WRA    = ir_rx;
        DONE   = 1'b1;
      end
      S_NOP:   DONE = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
module tb_regfile_sequencer;

  logic       CLKb, RSTb, EXEC;
  logic [9:0] INSTR;
  logic       BUSY, DONE, ENW, ENR0, ENR1, EXT_EN, ALU_LD, G_OUT;
  logic [1:0] WRA, RDA0, RDA1;
  logic [2:0] ALU_OP;

  int tests = 0;
  int fails = 0;

  regfile_sequencer #(.N(10), .AW(2)) dut (
    .CLKb   (CLKb),
    .RSTb   (RSTb),
    .INSTR  (INSTR),
    .EXEC   (EXEC),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .ENW    (ENW),
    .WRA    (WRA),
    .ENR0   (ENR0),
    .RDA0   (RDA0),
    .ENR1   (ENR1),
    .RDA1   (RDA1),
    .EXT_EN (EXT_EN),
    .ALU_LD (ALU_LD),
    .ALU_OP (ALU_OP),
    .G_OUT  (G_OUT)
  );

  initial begin
    CLKb = 1'b0;
    forever #5 CLKb = ~CLKb;
  end

  // Output vector: {BUSY,DONE,ENW,WRA,ENR0,RDA0,ENR1,RDA1,EXT_EN,ALU_LD,ALU_OP,G_OUT}
  localparam logic [16:0] O_IDLE = '0;

  function automatic logic [16:0] o_ld(input logic [1:0] wra);
    return {1'b1, 1'b1, 1'b1, wra, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 3'd0, 1'b0};
  endfunction

  function automatic logic [16:0] o_rd(input logic [1:0] a, input logic [1:0] b,
                                       input logic [2:0] op);
    return {1'b1, 1'b0, 1'b0, 2'd0, 1'b1, a, 1'b1, b, 1'b0, 1'b1, op, 1'b0};
  endfunction

  function automatic logic [16:0] o_wb(input logic [1:0] wra);
    return {1'b1, 1'b1, 1'b1, wra, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b1};
  endfunction

  localparam logic [16:0] O_NOP = {1'b1, 1'b1, 15'd0};

  function automatic logic [16:0] actual();
    return {BUSY, DONE, ENW, WRA, ENR0, RDA0, ENR1, RDA1, EXT_EN, ALU_LD, ALU_OP, G_OUT};
  endfunction

  task automatic chk(input string name, input logic [16:0] exp);
    logic [16:0] act;
    act = actual();
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %05h expected %05h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLKb);
    #1;
  endtask

  typedef struct {
    string       name;
    logic [9:0]  instr;
    logic        exec;
    logic [16:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(input string name, input logic [9:0] instr, input logic exec,
                      input logic [16:0] exp);
    vec_t v;
    v.name  = name;
    v.instr = instr;
    v.exec  = exec;
    v.exp   = exp;
    vecs.push_back(v);
  endtask

  localparam logic [9:0] LOAD_R2 = 10'b0000_10_00_00;
  localparam logic [9:0] LOAD_R3 = 10'b0000_11_00_00;
  localparam logic [9:0] LOAD_R1 = 10'b0000_01_00_00;
  localparam logic [9:0] ADD_13  = 10'b0010_01_11_00;
  localparam logic [9:0] ADD_11  = 10'b0010_01_01_00;
  localparam logic [9:0] SUB_02  = 10'b0011_00_10_00;
  localparam logic [9:0] NOT_3   = 10'b0111_11_00_00;
  localparam logic [9:0] MOV_21  = 10'b0001_10_01_00;
  localparam logic [9:0] AND_23  = 10'b0100_10_11_00;
  localparam logic [9:0] OR_01   = 10'b0101_00_01_11;
  localparam logic [9:0] XOR_32  = 10'b0110_11_10_01;
  localparam logic [9:0] ILL_F   = 10'b1111_00_00_00;
  localparam logic [9:0] ILL_8   = 10'b1000_11_10_00;

  initial begin
    RSTb  = 1'b0;
    EXEC  = 1'b0;
    INSTR = '0;
    #1;
    chk("reset_initial", O_IDLE);
    EXEC  = 1'b1;
    INSTR = LOAD_R2;
    step();
    chk("reset_holds_exec", O_IDLE);
    EXEC  = 1'b0;
    RSTb  = 1'b1;

    addv("idle",           10'd0,   1'b0, O_IDLE);
    addv("load_r2",        LOAD_R2, 1'b1, o_ld(2'd2));
    addv("load_to_idle",   10'd0,   1'b0, O_IDLE);
    addv("add13_rd",       ADD_13,  1'b1, o_rd(2'd1, 2'd3, 3'd1));
    addv("add13_wb",       10'd0,   1'b0, o_wb(2'd1));
    addv("add_to_idle",    10'd0,   1'b0, O_IDLE);
    addv("sub02_rd",       SUB_02,  1'b1, o_rd(2'd0, 2'd2, 3'd2));
    addv("sub02_wb",       NOT_3,   1'b1, o_wb(2'd0));
    addv("not3_rd_b2b",    NOT_3,   1'b1, o_rd(2'd3, 2'd0, 3'd6));
    addv("not3_wb",        10'd0,   1'b0, o_wb(2'd3));
    addv("not_to_idle",    10'd0,   1'b0, O_IDLE);
    addv("illegal_f_nop",  ILL_F,   1'b1, O_NOP);
    addv("illegal_8_b2b",  ILL_8,   1'b1, O_NOP);
    addv("nop_to_idle",    10'd0,   1'b0, O_IDLE);
    addv("mov21_rd",       MOV_21,  1'b1, o_rd(2'd2, 2'd1, 3'd0));
    addv("mov21_wb_ign",   LOAD_R3, 1'b1, o_wb(2'd2));
    addv("load_r3_b2b",    LOAD_R3, 1'b1, o_ld(2'd3));
    addv("add11_rd_b2b",   ADD_11,  1'b1, o_rd(2'd1, 2'd1, 3'd1));
    addv("add11_wb",       10'd0,   1'b0, o_wb(2'd1));
    addv("and23_rd",       AND_23,  1'b1, o_rd(2'd2, 2'd3, 3'd3));
    addv("and23_wb",       10'd0,   1'b0, o_wb(2'd2));
    addv("or01_rd",        OR_01,   1'b1, o_rd(2'd0, 2'd1, 3'd4));
    addv("or01_wb_ign",    XOR_32,  1'b1, o_wb(2'd0));
    addv("xor32_rd_b2b",   XOR_32,  1'b1, o_rd(2'd3, 2'd2, 3'd5));
    addv("xor32_wb",       10'd0,   1'b0, o_wb(2'd3));
    addv("final_idle",     10'd0,   1'b0, O_IDLE);

    foreach (vecs[i]) begin
      INSTR = vecs[i].instr;
      EXEC  = vecs[i].exec;
      step();
      chk(vecs[i].name, vecs[i].exp);
    end

    // Asynchronous reset in the read cycle of an ADD: no write-back may follow.
    INSTR = ADD_13;
    EXEC  = 1'b1;
    step();
    chk("abort_rd", o_rd(2'd1, 2'd3, 3'd1));
    EXEC = 1'b0;
    #3;
    RSTb = 1'b0;
    #1;
    chk("abort_async_clear", O_IDLE);
    for (int unsigned k = 0; k < 2; k++) begin
      step();
      chk("abort_no_write", O_IDLE);
    end
    RSTb = 1'b1;
    step();
    chk("after_reset_idle", O_IDLE);
    INSTR = LOAD_R1;
    EXEC  = 1'b1;
    step();
    chk("after_reset_load", o_ld(2'd1));
    EXEC = 1'b0;
    step();
    chk("after_reset_done", O_IDLE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
